// File: rtl/multimode_counter.sv
// multimode_counter: parametrised wide counter with up/down direction,
// synchronous clear/load, runtime modulo limit (wrap or saturate),
// clock-enable prescaler, terminal-count pulse and sticky wrap flag.
//
// Priority each cycle: clear > load > prescaled count step.
// tick/tc are registered and line up with the out value produced by the step.
module multimode_counter #(
    parameter int WIDTH          = 129,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      enable,
    input  logic                      up_down,
    input  logic                      saturate,
    input  logic [WIDTH-1:0]          limit,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]          out,
    output logic                      tick,
    output logic                      tc,
    output logic                      wrapped
);

    localparam logic [WIDTH-1:0]          CNT_ZERO = '0;
    localparam logic [WIDTH-1:0]          CNT_ONE  = WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] P_ZERO   = '0;
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE    = PRESCALE_WIDTH'(1);

    logic [WIDTH-1:0]          out_q, out_d;
    logic [PRESCALE_WIDTH-1:0] p_q, p_d;
    logic                      tick_q, tick_d;
    logic                      tc_q, tc_d;
    logic                      wrapped_q, wrapped_d;
    logic                      step_en;

    // Prescaler compare: a step fires when the enabled-cycle count reaches prescale.
    // Lowering prescale below p does not re-arm; p simply runs through its wrap.
    always_comb begin
        step_en = enable && (p_q == prescale);
    end

    // Next-state logic: clear, then load, then a prescaled count step.
    always_comb begin
        out_d     = out_q;
        p_d       = p_q;
        tick_d    = 1'b0;
        tc_d      = 1'b0;
        wrapped_d = wrapped_q;

        if (clear) begin
            out_d     = CNT_ZERO;
            p_d       = P_ZERO;
            wrapped_d = 1'b0;
        end else if (load) begin
            // Values above limit are accepted as-is; the next step resolves them.
            out_d = load_value;
            p_d   = P_ZERO;
        end else if (enable) begin
            p_d = step_en ? P_ZERO : (p_q + P_ONE);
            if (step_en) begin
                tick_d = 1'b1;
                if (up_down) begin
                    if (out_q < limit) begin
                        out_d = out_q + CNT_ONE;
                    end else if (saturate) begin
                        out_d = limit;
                        tc_d  = 1'b1;
                    end else begin
                        out_d     = CNT_ZERO;
                        tc_d      = 1'b1;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    // Counting down from above limit is allowed; only zero is a boundary.
                    if (out_q != CNT_ZERO) begin
                        out_d = out_q - CNT_ONE;
                    end else if (saturate) begin
                        out_d = CNT_ZERO;
                        tc_d  = 1'b1;
                    end else begin
                        out_d     = limit;
                        tc_d      = 1'b1;
                        wrapped_d = 1'b1;
                    end
                end
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= CNT_ZERO;
            p_q       <= P_ZERO;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            p_q       <= p_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign out     = out_q;
    assign tick    = tick_q;
    assign tc      = tc_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Directed, table-driven bench for multimode_counter at default width (129 bits).
module tb_multimode_counter;

  localparam int W  = 129;
  localparam int PW = 8;
  localparam logic [W-1:0] ALL1 = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic          enable = 1'b0;
  logic          up_down = 1'b1;
  logic          saturate = 1'b0;
  logic [W-1:0]  limit = '1;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  out;
  logic          tick;
  logic          tc;
  logic          wrapped;

  multimode_counter #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_value(load_value), .enable(enable), .up_down(up_down),
    .saturate(saturate), .limit(limit), .prescale(prescale),
    .out(out), .tick(tick), .tc(tc), .wrapped(wrapped)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic          clr;
    logic          ld;
    logic [W-1:0]  lv;
    logic          en;
    logic          ud;
    logic          sat;
    logic [W-1:0]  lim;
    logic [PW-1:0] ps;
    logic [W-1:0]  e_out;
    logic          e_tick;
    logic          e_tc;
    logic          e_wr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic clr, input logic ld, input logic [W-1:0] lv,
                     input logic en, input logic ud, input logic sat,
                     input logic [W-1:0] lim, input logic [PW-1:0] ps,
                     input logic [W-1:0] e_out, input logic e_tick,
                     input logic e_tc, input logic e_wr);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.en = en; v.ud = ud; v.sat = sat;
    v.lim = lim; v.ps = ps; v.e_out = e_out; v.e_tick = e_tick;
    v.e_tc = e_tc; v.e_wr = e_wr;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] e_out,
                         input logic e_tick, input logic e_tc, input logic e_wr);
    chk({tag, " out"}, out, e_out);
    chk({tag, " tick"}, W'(tick), W'(e_tick));
    chk({tag, " tc"}, W'(tc), W'(e_tc));
    chk({tag, " wrapped"}, W'(wrapped), W'(e_wr));
  endtask

  // ---------------- driver ----------------
  task automatic apply(input vec_t v);
    @(negedge clk);
    clear = v.clr; load = v.ld; load_value = v.lv; enable = v.en;
    up_down = v.ud; saturate = v.sat; limit = v.lim; prescale = v.ps;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: free-running up count, full-range limit
    for (int i = 1; i <= 5; i++) add(0,0,0, 1,1,0, ALL1,0, W'(i),1,0,0);
    // 2: limit=3 wrap
    add(1,0,0, 1,1,0, ALL1,0, 0,0,0,0);
    add(0,0,0, 1,1,0, 3,0, 1,1,0,0);
    add(0,0,0, 1,1,0, 3,0, 2,1,0,0);
    add(0,0,0, 1,1,0, 3,0, 3,1,0,0);
    add(0,0,0, 1,1,0, 3,0, 0,1,1,1);
    add(0,0,0, 1,1,0, 3,0, 1,1,0,1);
    add(0,0,0, 1,1,0, 3,0, 2,1,0,1);
    // 3: saturate up at limit=3, then down to 0 and hold
    add(1,0,0, 1,1,0, 3,0, 0,0,0,0);
    add(0,1,2, 1,1,1, 3,0, 2,0,0,0);
    add(0,0,0, 1,1,1, 3,0, 3,1,0,0);
    add(0,0,0, 1,1,1, 3,0, 3,1,1,0);
    add(0,0,0, 1,1,1, 3,0, 3,1,1,0);
    add(0,0,0, 1,0,1, 3,0, 2,1,0,0);
    add(0,0,0, 1,0,1, 3,0, 1,1,0,0);
    add(0,0,0, 1,0,1, 3,0, 0,1,0,0);
    add(0,0,0, 1,0,1, 3,0, 0,1,1,0);
    // 4: prescale=2 with enable 1,1,0,1,1,1,1
    add(0,0,0, 1,1,0, ALL1,2, 0,0,0,0);
    add(0,0,0, 1,1,0, ALL1,2, 0,0,0,0);
    add(0,0,0, 0,1,0, ALL1,2, 0,0,0,0);
    add(0,0,0, 1,1,0, ALL1,2, 1,1,0,0);
    add(0,0,0, 1,1,0, ALL1,2, 1,0,0,0);
    add(0,0,0, 1,1,0, ALL1,2, 1,0,0,0);
    add(0,0,0, 1,1,0, ALL1,2, 2,1,0,0);
    // 5: load above limit, then wrap; reload and count down from above limit
    add(0,1,10, 1,1,0, 5,0, 10,0,0,0);
    add(0,0,0, 1,1,0, 5,0, 0,1,1,1);
    add(0,1,10, 1,0,0, 5,0, 10,0,0,1);
    add(0,0,0, 1,0,0, 5,0, 9,1,0,1);
    add(0,0,0, 1,0,0, 5,0, 8,1,0,1);
    add(0,0,0, 0,0,0, 5,0, 8,0,0,1);
    add(0,0,0, 1,0,0, 5,0, 7,1,0,1);
    // 6: clear beats load; limit=0; load keeps wrapped; full-width wrap both ways
    add(1,1,10, 1,1,0, 5,0, 0,0,0,0);
    add(0,0,0, 1,1,0, 0,0, 0,1,1,1);
    add(0,0,0, 1,0,1, 0,0, 0,1,1,1);
    add(0,1,4, 1,1,0, 0,0, 4,0,0,1);
    add(0,1,ALL1, 1,1,0, ALL1,0, ALL1,0,0,1);
    add(0,0,0, 1,1,0, ALL1,0, 0,1,1,1);
    add(0,0,0, 1,0,0, ALL1,0, ALL1,1,1,1);

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_tick, vecs[i].e_tc, vecs[i].e_wr);
    end

    // reset mid-count acts immediately, without a clock edge
    @(negedge clk);
    clear = 0; load = 0; enable = 1; up_down = 1; saturate = 0; limit = ALL1; prescale = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("precount", 2, 1, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("reset_hold", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_reset", 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
